// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Contents:
//   RF_DATA_W / RF_ADDR_W / RF_NUM_REGS : default geometry (32 x 32-bit, 5-bit addresses)
//   rf_addr_valid()                     : address legality check, used by both the data
//                                         array and the scoreboard so they always agree
package rf_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NUM_REGS = 32;

  // An address is usable when it names an implemented register and is not the
  // hardwired zero register. Addresses are widened to 32 bits by the caller.
  function automatic logic rf_addr_valid(input logic [31:0] addr,
                                         input int unsigned num_regs,
                                         input bit          zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending (busy) tracker for long-latency producers.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   i_wr_en/addr   : writeback, clears the pending bit of a valid address
//   i_rsv_en/addr  : reservation, sets the pending bit of a valid address
//   i_flush        : clears every pending bit
//   o_pending      : pending vector, one bit per implemented register
//   o_pend_cnt     : registered popcount of o_pending
//   o_err_waw      : registered pulse, a reservation hit an already-pending register
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic                i_rsv_en,
  input  logic [ADDR_W-1:0]   i_rsv_addr,
  input  logic                i_flush,
  output logic [NUM_REGS-1:0] o_pending,
  output logic [ADDR_W:0]     o_pend_cnt,
  output logic                o_err_waw
);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_d;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_d;
  logic                r_err;
  logic                w_err_d;
  logic                w_wr_hit;
  logic                w_rsv_hit;
  logic                w_rsv_pend;

  assign w_wr_hit  = i_wr_en  && rf_addr_valid(32'(i_wr_addr), NUM_REGS, ZERO_REG);
  assign w_rsv_hit = i_rsv_en && rf_addr_valid(32'(i_rsv_addr), NUM_REGS, ZERO_REG);

  // Per bit: flush beats reserve, reserve beats write-clear.
  always_comb begin
    w_pend_d   = r_pend;
    w_rsv_pend = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rsv_hit && (i_rsv_addr == ADDR_W'(i))) w_rsv_pend = r_pend[i];
      if (w_wr_hit && (i_wr_addr == ADDR_W'(i)))   w_pend_d[i] = 1'b0;
      if (w_rsv_hit && (i_rsv_addr == ADDR_W'(i))) w_pend_d[i] = 1'b1;
    end
    if (i_flush) w_pend_d = '0;
  end

  // A same-edge writeback to the reserved register retires the old producer,
  // so that case is not a WAW conflict.
  assign w_err_d = w_rsv_hit && w_rsv_pend && !i_flush &&
                   !(w_wr_hit && (i_wr_addr == i_rsv_addr));

  always_comb begin
    w_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_d = w_cnt_d + {{ADDR_W{1'b0}}, w_pend_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_d;
      r_cnt  <= w_cnt_d;
      r_err  <= w_err_d;
    end
  end

  assign o_pending  = r_pend;
  assign o_pend_cnt = r_cnt;
  assign o_err_waw  = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with an integrated pending-bit scoreboard.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   i_rd_addr / o_rd_data: NUM_RD packed read ports, combinational
//   o_rd_busy            : per read port, addressed register is pending
//   i_wr_en/addr/data    : writeback (updates data, retires reservation)
//   i_rsv_en/addr        : mark destination pending
//   i_flush              : clear all pending bits
//   o_pend_cnt           : registered count of pending registers
//   o_err_waw            : registered pulse on reserving an already-pending register
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_pend_cnt,
  output logic                     o_err_waw
);

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_pending;
  logic                w_wr_hit;
  logic [ADDR_W-1:0]   w_ra       [NUM_RD];
  logic [NUM_RD-1:0]   w_ra_valid;

  assign w_wr_hit = i_wr_en && rf_addr_valid(32'(i_wr_addr), NUM_REGS, ZERO_REG);

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_flush    (i_flush),
    .o_pending  (w_pending),
    .o_pend_cnt (o_pend_cnt),
    .o_err_waw  (o_err_waw)
  );

  // Flush never touches data; the zero register is never written so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit && (i_wr_addr == ADDR_W'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
    assign w_ra[k]       = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_ra_valid[k] = rf_addr_valid(32'(w_ra[k]), NUM_REGS, ZERO_REG);
  end

  // Invalid addresses read as 0 / not busy. A same-cycle write wins over the
  // stored value and hides the pending bit it is about to clear.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_ra_valid[k]) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_ra[k] == ADDR_W'(i)) begin
            o_rd_data[k*DATA_W +: DATA_W] = r_mem[i];
            o_rd_busy[k]                  = w_pending[i];
          end
        end
        if (BYPASS && w_wr_hit && (i_wr_addr == w_ra[k])) begin
          o_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
          o_rd_busy[k]                  = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int NR = 24;  // fewer than 2**ADDR_W so out-of-range addresses exist
  localparam int NP = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rsv_en = 1'b0;
  logic [AW-1:0]     rsv_addr = '0;
  logic              flush = 1'b0;
  logic [AW:0]       pend_cnt;
  logic              err_waw;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [DW-1:0] m_mem  [NR];
  bit            m_pend [NR];
  int            m_cnt;
  bit            m_err;

  always #5 clk = ~clk;

  reg_file_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NR),
    .NUM_RD   (NP),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_flush    (flush),
    .o_pend_cnt (pend_cnt),
    .o_err_waw  (err_waw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid(input int a);
    return (a < NR) && (a != 0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Check every read port against the reference for the current inputs.
  task automatic check_reads(input string tag);
    logic [DW-1:0] ed;
    bit            eb;
    int            a;
    for (int k = 0; k < NP; k++) begin
      a  = int'(rd_addr[k*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      if (m_valid(a)) begin
        if (wr_en && m_valid(int'(wr_addr)) && (int'(wr_addr) == a)) begin
          ed = wr_data;
        end else begin
          ed = m_mem[a];
          eb = m_pend[a];
        end
      end
      check($sformatf("%s rd_data%0d", tag, k), rd_data[k*DW +: DW], ed);
      check($sformatf("%s rd_busy%0d", tag, k), 32'(rd_busy[k]), 32'(eb));
    end
  endtask

  // One clock: drive at negedge, check reads, advance model, check registered outputs.
  task automatic cyc(input string tag, input bit we, input int wa, input logic [DW-1:0] wd,
                     input bit re, input int ra, input bit fl,
                     input int a0, input int a1, input int a2);
    bit wv, rv, e;
    @(negedge clk);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = AW'(ra);
    flush    = fl;
    rd_addr  = {AW'(a2), AW'(a1), AW'(a0)};
    #1;
    check_reads(tag);
    wv = we && m_valid(wa);
    rv = re && m_valid(ra);
    e  = rv && m_pend[ra] && !(wv && (wa == ra)) && !fl;
    @(posedge clk);
    #1;
    if (wv) m_mem[wa] = wd;
    if (fl) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end else begin
      if (wv) m_pend[wa] = 1'b0;
      if (rv) m_pend[ra] = 1'b1;
    end
    m_err = e;
    m_cnt = 0;
    for (int i = 0; i < NR; i++) m_cnt += int'(m_pend[i]);
    check({tag, " pend_cnt"}, 32'(pend_cnt), 32'(m_cnt));
    check({tag, " err_waw"}, 32'(err_waw), 32'(m_err));
  endtask

  task automatic idle(input string tag, input int a0);
    cyc(tag, 1'b0, 0, '0, 1'b0, 0, 1'b0, a0, 0, 0);
  endtask

  task automatic rnd_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cyc("rnd", ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 9) < 4), int'($urandom_range(0, 31)),
          ($urandom_range(0, 19) == 0),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    m_reset();
    #12;
    check("reset pend_cnt", 32'(pend_cnt), 32'd0);
    check("reset err_waw", 32'(err_waw), 32'd0);
    rst_n = 1'b1;

    // Write then read back; zero register ignores writes.
    cyc("wr5", 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 0, 0);
    idle("rd5", 5);
    check("r5 data", rd_data[0 +: DW], 32'hDEAD_BEEF);
    cyc("wr0", 1'b1, 0, 32'h1, 1'b0, 0, 1'b0, 0, 0, 0);
    check("r0 data", rd_data[0 +: DW], 32'h0);

    // Bypass on port 1.
    cyc("byp7", 1'b1, 7, 32'h1234, 1'b0, 0, 1'b0, 0, 7, 0);
    check("byp r7 data", rd_data[DW +: DW], 32'h1234);
    check("byp r7 busy", 32'(rd_busy[1]), 32'd0);

    // Reserve then retire r3.
    cyc("rsv3", 1'b0, 0, '0, 1'b1, 3, 1'b0, 3, 0, 0);
    check("rsv3 busy", 32'(rd_busy[0]), 32'd1);
    check("rsv3 cnt", 32'(pend_cnt), 32'd1);
    cyc("wr3", 1'b1, 3, 32'h55, 1'b0, 0, 1'b0, 3, 0, 0);
    idle("rd3", 3);
    check("wr3 busy", 32'(rd_busy[0]), 32'd0);
    check("wr3 data", rd_data[0 +: DW], 32'h55);
    check("wr3 cnt", 32'(pend_cnt), 32'd0);

    // Double reservation gives a single WAW pulse.
    cyc("waw a", 1'b0, 0, '0, 1'b1, 3, 1'b0, 3, 0, 0);
    check("waw first", 32'(err_waw), 32'd0);
    cyc("waw b", 1'b0, 0, '0, 1'b1, 3, 1'b0, 3, 0, 0);
    check("waw second", 32'(err_waw), 32'd1);
    idle("waw c", 3);
    check("waw cleared", 32'(err_waw), 32'd0);

    // Reserve and write the same register at one edge.
    cyc("rsvwr3", 1'b1, 3, 32'hAA, 1'b1, 3, 1'b0, 0, 0, 0);
    check("rsvwr3 err", 32'(err_waw), 32'd0);
    idle("rsvwr3 rd", 3);
    check("rsvwr3 busy", 32'(rd_busy[0]), 32'd1);
    check("rsvwr3 data", rd_data[0 +: DW], 32'hAA);

    // Flush wins over a coincident reservation.
    cyc("rsv1", 1'b0, 0, '0, 1'b1, 1, 1'b0, 0, 0, 0);
    cyc("rsv2", 1'b0, 0, '0, 1'b1, 2, 1'b0, 0, 0, 0);
    cyc("rsv4", 1'b0, 0, '0, 1'b1, 4, 1'b0, 0, 0, 0);
    check("pre flush cnt", 32'(pend_cnt), 32'd4);
    cyc("flush", 1'b0, 0, '0, 1'b1, 6, 1'b1, 6, 0, 0);
    check("flush cnt", 32'(pend_cnt), 32'd0);
    check("flush r6 busy", 32'(rd_busy[0]), 32'd0);

    // Out-of-range address is ignored.
    cyc("oor", 1'b1, 30, 32'h77, 1'b1, 30, 1'b0, 30, 0, 0);
    check("oor data", rd_data[0 +: DW], 32'h0);
    check("oor cnt", 32'(pend_cnt), 32'd0);

    rnd_cycles(1500);

    // Asynchronous reset mid-run.
    @(negedge clk);
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("arst pend_cnt", 32'(pend_cnt), 32'd0);
    check("arst err_waw", 32'(err_waw), 32'd0);
    for (int a = 0; a < 24; a += NP) begin
      rd_addr = {AW'(a + 2), AW'(a + 1), AW'(a)};
      #1;
      check_reads("arst");
    end
    @(negedge clk);
    rst_n = 1'b1;

    rnd_cycles(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
